div_pipe_arbiter: RTL and testbench

DIV_PIPE_ARBITER -- requirements
Module: div_pipe_arbiter

---
 rtl/div_pipe_arbiter.sv | 156 +++++++++++++++
 tb/tb_div_pipe_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_pipe_arbiter.sv
// Round-robin arbiter sharing one pipelined divider among NREQ requesters, with in-order tag FIFO.
// Define DIV_PIPE_ARBITER_PERF_EN to add grant_count/stall_count performance counters.
module div_pipe_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned MAX_OUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*WIDTH-1:0]        req_dividend,
    input  logic [NREQ*WIDTH-1:0]        req_divisor,
    output logic [NREQ-1:0]              req_ready,
    output logic                         div_start,
    output logic [WIDTH-1:0]             div_dividend,
    output logic [WIDTH-1:0]             div_divisor,
    input  logic                         div_data_valid,
    input  logic [WIDTH-1:0]             div_quotient,
    input  logic                         div_by_zero,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [WIDTH-1:0]             rsp_quotient,
    output logic                         rsp_div_by_zero,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         err_orphan
`ifdef DIV_PIPE_ARBITER_PERF_EN
    ,
    output logic [NREQ-1:0][31:0]        grant_count,
    output logic [31:0]                  stall_count
`endif
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    logic [IW-1:0]    prio_q;  // requester with the highest priority this cycle
    logic [IW-1:0]    gnt_idx;
    logic             gnt_found;
    logic [IW-1:0]    tag_mem [MAX_OUT];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             accept;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        int unsigned   cand;
        logic [IW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(prio_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = cand[IW-1:0];
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                sel_dividend = req_dividend[i*WIDTH +: WIDTH];
                sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(MAX_OUT));
    assign pop        = div_data_valid && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign accept     = gnt_found && (!fifo_full || pop) && !rst;

    always_comb begin
        req_ready          = '0;
        req_ready[gnt_idx] = accept;
    end

    assign outstanding = count_q;

    always_ff @(posedge clk) begin
        if (accept) tag_mem[wr_ptr_q] <= gnt_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            div_start       <= 1'b0;
            div_dividend    <= '0;
            div_divisor     <= '0;
            rsp_valid       <= '0;
            rsp_quotient    <= '0;
            rsp_div_by_zero <= 1'b0;
            err_orphan      <= 1'b0;
        end else begin
            div_start <= accept;
            if (accept) begin
                div_dividend <= sel_dividend;
                div_divisor  <= sel_divisor;
                wr_ptr_q     <= ptr_inc(wr_ptr_q);
                prio_q       <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            rsp_valid <= '0;
            if (pop) begin
                rsp_valid[tag_mem[rd_ptr_q]] <= 1'b1;
                rsp_quotient                 <= div_quotient;
                rsp_div_by_zero              <= div_by_zero;
                rd_ptr_q                     <= ptr_inc(rd_ptr_q);
            end
            // Results with no pending tag are dropped and flagged.
            if (div_data_valid && fifo_empty) err_orphan <= 1'b1;
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef DIV_PIPE_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count <= '0;
            stall_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (accept && gnt_idx == IW'(i) && grant_count[i] != '1) begin
                    grant_count[i] <= grant_count[i] + 1'b1;
                end
            end
            if ((|req_valid) && !accept && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_pipe_arbiter.sv
// Directed bench for div_pipe_arbiter: divider model, response scoreboard, immediate-assert checks.
module tb_div_pipe_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 128;
    localparam int MAX_OUT = 4;
    localparam int CW      = $clog2(MAX_OUT + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic [NREQ-1:0]       req_ready;
    logic                  div_start;
    logic [WIDTH-1:0]      div_dividend;
    logic [WIDTH-1:0]      div_divisor;
    logic                  div_data_valid;
    logic [WIDTH-1:0]      div_quotient;
    logic                  div_by_zero;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_quotient;
    logic                  rsp_div_by_zero;
    logic [CW-1:0]         outstanding;
    logic                  err_orphan;
`ifdef DIV_PIPE_ARBITER_PERF_EN
    logic [NREQ-1:0][31:0] grant_count;
    logic [31:0]           stall_count;
`endif

    div_pipe_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_OUT(MAX_OUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_dividend    (req_dividend),
        .req_divisor     (req_divisor),
        .req_ready       (req_ready),
        .div_start       (div_start),
        .div_dividend    (div_dividend),
        .div_divisor     (div_divisor),
        .div_data_valid  (div_data_valid),
        .div_quotient    (div_quotient),
        .div_by_zero     (div_by_zero),
        .rsp_valid       (rsp_valid),
        .rsp_quotient    (rsp_quotient),
        .rsp_div_by_zero (rsp_div_by_zero),
        .outstanding     (outstanding),
        .err_orphan      (err_orphan)
`ifdef DIV_PIPE_ARBITER_PERF_EN
        ,
        .grant_count     (grant_count),
        .stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] q;
        logic             dbz;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             dbz;
        int               due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    lat = 2;
    bit    stall = 1'b0;
    int    rel_cnt = 0;
    int    rsp_seen = 0;

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_dividend[i*WIDTH +: WIDTH] = a;
        req_divisor[i*WIDTH +: WIDTH]  = b;
    endtask

    // Scoreboard: expectations pushed on accept, popped on each response.
    always @(posedge clk) begin
        exp_t            e;
        logic [NREQ-1:0] acc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        cyc++;
        if (rsp_valid != '0) begin
            rsp_seen++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected: observed rsp_valid %b expected none", rsp_valid);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_route", WIDTH'(rsp_valid), WIDTH'(onehot(e.idx)));
                chk("rsp_quotient", rsp_quotient, e.q);
                chk("rsp_dbz", WIDTH'(rsp_div_by_zero), WIDTH'(e.dbz));
            end
        end
        acc = req_valid & req_ready;
        if (rst) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    a     = req_dividend[i*WIDTH +: WIDTH];
                    b     = req_divisor[i*WIDTH +: WIDTH];
                    e.idx = i;
                    e.dbz = (b == '0);
                    e.q   = (b == '0) ? '1 : a / b;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Divider model: fixed latency from div_start, or held until released when stalled.
    always @(posedge clk) begin
        pend_t p;
        #2;
        if (div_start) begin
            p.dbz = (div_divisor == '0);
            p.q   = p.dbz ? '1 : div_dividend / div_divisor;
            p.due = cyc + lat;
            pend_q.push_back(p);
        end
        div_data_valid = 1'b0;
        if (pend_q.size() != 0) begin
            if (stall) begin
                if (rel_cnt > 0) begin
                    p = pend_q.pop_front();
                    div_data_valid = 1'b1;
                    div_quotient   = p.q;
                    div_by_zero    = p.dbz;
                    rel_cnt--;
                end
            end else if (pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                div_data_valid = 1'b1;
                div_quotient   = p.q;
                div_by_zero    = p.dbz;
            end
        end
    end

    initial begin
        int               k;
        int               acc;
        int               base;
        logic [WIDTH-1:0] held;

        rst            = 1'b1;
        req_valid      = '1;
        req_dividend   = '0;
        req_divisor    = '0;
        div_data_valid = 1'b0;
        div_quotient   = '0;
        div_by_zero    = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(1000 + 37 * i), WIDTH'(i + 3));

        // Reset state with all requesters asserting valid
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", WIDTH'(req_ready), '0);
        chk("rst_start", WIDTH'(div_start), '0);
        chk("rst_dividend", div_dividend, '0);
        chk("rst_rsp_valid", WIDTH'(rsp_valid), '0);
        chk("rst_quotient", rsp_quotient, '0);
        chk("rst_outstanding", WIDTH'(outstanding), '0);
        chk("rst_orphan", WIDTH'(err_orphan), '0);

        // All four continuously valid: rotating grants, div_start every cycle
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_grant", WIDTH'(req_ready), WIDTH'(onehot(c % 4)));
            if (c > 0) chk("rr_start", WIDTH'(div_start), WIDTH'(1));
            @(negedge clk);
        end
        req_valid = '0;
        for (int i = 0; i < 60 && (outstanding != '0 || exp_q.size() != 0); i++) @(negedge clk);
        chk("rr_drain", WIDTH'(outstanding), '0);

        // Requester 2 alone: 100/7 through a 10-cycle divider
        lat = 10;
        set_op(2, WIDTH'(100), WIDTH'(7));
        req_valid = 4'b0100;
        #1;
        chk("lat_ready", WIDTH'(req_ready), WIDTH'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        chk("lat_start", WIDTH'(div_start), WIDTH'(1));
        chk("lat_dividend", div_dividend, WIDTH'(100));
        chk("lat_divisor", div_divisor, WIDTH'(7));
        @(negedge clk);
        chk("lat_start_pulse", WIDTH'(div_start), '0);
        k = 2;
        while (k < 40 && rsp_valid == '0) begin
            @(negedge clk);
            k++;
        end
        chk("lat_rsp_cycle", WIDTH'(k), WIDTH'(12));
        chk("lat_rsp_valid", WIDTH'(rsp_valid), WIDTH'(4'b0100));
        chk("lat_quotient", rsp_quotient, WIDTH'(14));
        chk("lat_dbz", WIDTH'(rsp_div_by_zero), '0);

        // Requester 1 divides by zero; quotient then holds while idle
        lat = 2;
        set_op(1, WIDTH'(55), '0);
        req_valid = 4'b0010;
        #1;
        chk("dbz_ready", WIDTH'(req_ready), WIDTH'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        k = 0;
        while (k < 40 && rsp_valid == '0) begin
            @(negedge clk);
            k++;
        end
        chk("dbz_rsp_valid", WIDTH'(rsp_valid), WIDTH'(4'b0010));
        chk("dbz_flag", WIDTH'(rsp_div_by_zero), WIDTH'(1));
        held = rsp_quotient;
        @(negedge clk);
        chk("hold_valid", WIDTH'(rsp_valid), '0);
        chk("hold_quotient", rsp_quotient, held);

        // Stalled divider: fill to MAX_OUT, then free one slot
        stall = 1'b1;
        set_op(3, WIDTH'(900), WIDTH'(30));
        req_valid = 4'b1000;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (req_ready[3]) acc++;
            @(negedge clk);
        end
        #1;
        chk("full_accepts", WIDTH'(acc), WIDTH'(4));
        chk("full_ready", WIDTH'(req_ready), '0);
        chk("full_outstanding", WIDTH'(outstanding), WIDTH'(4));
        req_valid = '0;
        rel_cnt = 1;
        repeat (2) @(negedge clk);
        chk("free_outstanding", WIDTH'(outstanding), WIDTH'(3));
        req_valid = 4'b1000;
        #1;
        chk("free_ready", WIDTH'(req_ready), WIDTH'(4'b1000));
        @(negedge clk);
        #1;
        chk("refill_outstanding", WIDTH'(outstanding), WIDTH'(4));
        chk("refill_ready", WIDTH'(req_ready), '0);
        rel_cnt = 1;
        @(negedge clk);
        #1;
        // Pop and accept in the same cycle while full
        chk("swap_ready", WIDTH'(req_ready), WIDTH'(4'b1000));
        chk("swap_outstanding", WIDTH'(outstanding), WIDTH'(4));
        @(negedge clk);
        req_valid = '0;
        chk("swap_after", WIDTH'(outstanding), WIDTH'(4));
        rel_cnt = 1;
        repeat (2) @(negedge clk);
        chk("pre_rst_outstanding", WIDTH'(outstanding), WIDTH'(3));
        chk("pre_rst_orphan", WIDTH'(err_orphan), '0);

        // Reset with 3 in flight; late results become orphans
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_outstanding", WIDTH'(outstanding), '0);
        chk("mid_rst_rsp", WIDTH'(rsp_valid), '0);
        rst   = 1'b0;
        stall = 1'b0;
        base  = rsp_seen;
        repeat (8) @(negedge clk);
        chk("orphan_no_rsp", WIDTH'(rsp_seen - base), '0);
        chk("orphan_flag", WIDTH'(err_orphan), WIDTH'(1));
        chk("orphan_outstanding", WIDTH'(outstanding), '0);
        chk("orphan_drained", WIDTH'(pend_q.size()), '0);

`ifdef DIV_PIPE_ARBITER_PERF_EN
        // 10 accepts on requester 0, then 5 contended cycles against a full FIFO
        set_op(0, WIDTH'(77), WIDTH'(7));
        req_valid = 4'b0001;
        repeat (10) @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 60 && (outstanding != '0 || exp_q.size() != 0); i++) @(negedge clk);
        stall = 1'b1;
        req_valid = 4'b0010;
        repeat (9) @(negedge clk);
        req_valid = '0;
        chk("perf_grant0", WIDTH'(grant_count[0]), WIDTH'(10));
        chk("perf_grant1", WIDTH'(grant_count[1]), WIDTH'(4));
        chk("perf_stall", WIDTH'(stall_count), WIDTH'(5));
        stall = 1'b0;
        for (int i = 0; i < 60 && (outstanding != '0 || exp_q.size() != 0); i++) @(negedge clk);
`endif

        chk("final_scoreboard", WIDTH'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
